// File: rtl/alt_sync_ram.sv
`default_nettype none
// ============================================================================
//  Module   : alt_sync_ram
//  Brief    : Simple-dual-port synchronous RAM, one clock, registered read with
//             latency 1 or 2, byte-lane writes, selectable read-during-write.
//  Revision : 1.0
// ============================================================================
module alt_sync_ram #(
    parameter int                    DATA_WIDTH        = 32,
    parameter int                    BYTE_WIDTH        = 32,
    parameter int                    SIZE              = 1024,
    parameter int                    ADDR_WIDTH        = (SIZE > 1) ? $clog2(SIZE) : 1,
    parameter int                    READ_LATENCY      = 1,
    parameter string                 READ_DURING_WRITE = "OLD_DATA",
    parameter logic [DATA_WIDTH-1:0] RESET_VALUE       = '0
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             write_en,
    input  logic [DATA_WIDTH/BYTE_WIDTH-1:0] write_byte_en,
    input  logic [ADDR_WIDTH-1:0]            write_adr,
    input  logic [DATA_WIDTH-1:0]            write_data,
    input  logic                             read_en,
    input  logic [ADDR_WIDTH-1:0]            read_adr,
    input  logic                             read_reg_en,
    output logic [DATA_WIDTH-1:0]            read_data
);

    localparam int                  c_lanes    = DATA_WIDTH / BYTE_WIDTH;
    localparam bit                  c_new_data = (READ_DURING_WRITE == "NEW_DATA");
    localparam logic [ADDR_WIDTH:0] c_size     = (ADDR_WIDTH + 1)'(SIZE);

    // Array is never reset; the declaration value only sets power-up contents.
    logic [DATA_WIDTH-1:0] r_mem [SIZE] = '{default: '0};

    logic [DATA_WIDTH-1:0] w_wr_mask;
    logic [DATA_WIDTH-1:0] w_mem_word;
    logic [DATA_WIDTH-1:0] w_rd_word;
    logic                  w_wr_hit;
    logic                  w_rd_hit;
    logic [DATA_WIDTH-1:0] r_stage1;

    assign w_wr_hit = write_en && ({1'b0, write_adr} < c_size);
    assign w_rd_hit = ({1'b0, read_adr} < c_size);

    for (genvar i = 0; i < c_lanes; i++) begin : g_lane_mask
        assign w_wr_mask[i*BYTE_WIDTH +: BYTE_WIDTH] = {BYTE_WIDTH{write_byte_en[i]}};
    end

    always_ff @(posedge clk) begin
        if (w_wr_hit) begin
            for (int i = 0; i < c_lanes; i++) begin
                if (write_byte_en[i]) begin
                    r_mem[write_adr][i*BYTE_WIDTH +: BYTE_WIDTH] <= write_data[i*BYTE_WIDTH +: BYTE_WIDTH];
                end
            end
        end
    end

    assign w_mem_word = w_rd_hit ? r_mem[read_adr] : '0;

    if (c_new_data) begin : g_bypass
        // Same-address collision: enabled lanes come from write_data, the
        // rest from the stored word, so stage1 sees the post-write value.
        logic                  w_collide;
        logic [DATA_WIDTH-1:0] w_merged;
        assign w_collide = w_wr_hit && (write_adr == read_adr);
        assign w_merged  = (w_mem_word & ~w_wr_mask) | (write_data & w_wr_mask);
        assign w_rd_word = w_collide ? w_merged : w_mem_word;
    end else begin : g_no_bypass
        logic [DATA_WIDTH-1:0] w_unused_mask;
        assign w_unused_mask = w_wr_mask;
        assign w_rd_word     = w_mem_word;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_stage1 <= RESET_VALUE;
        end else if (read_en) begin
            r_stage1 <= w_rd_word;
        end
    end

    if (READ_LATENCY == 2) begin : g_lat2
        logic [DATA_WIDTH-1:0] r_stage2;
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                r_stage2 <= RESET_VALUE;
            end else if (read_reg_en) begin
                r_stage2 <= r_stage1;
            end
        end
        assign read_data = r_stage2;
    end else begin : g_lat1
        logic w_unused_reg_en;
        assign w_unused_reg_en = read_reg_en;
        assign read_data       = r_stage1;
    end

endmodule
`default_nettype wire

// File: tb/tb_alt_sync_ram.sv
`default_nettype none
// ============================================================================
//  Module   : tb_alt_sync_ram
//  Brief    : Directed self-checking bench; three RAM configurations share one
//             stimulus stream (OLD_DATA, NEW_DATA, latency-2).
//  Revision : 1.0
// ============================================================================
module tb_alt_sync_ram;

    logic        clk;
    logic        reset;
    logic        write_en;
    logic [3:0]  write_byte_en;
    logic [3:0]  write_adr;
    logic [31:0] write_data;
    logic        read_en;
    logic [3:0]  read_adr;
    logic        read_reg_en;
    logic [31:0] rd_old;
    logic [31:0] rd_new;
    logic [31:0] rd_l2;

    int n_total = 0;
    int n_bad   = 0;

    localparam logic [31:0] c_l2_rst = 32'h0BAD_F00D;

    alt_sync_ram #(
        .DATA_WIDTH(32), .BYTE_WIDTH(8), .SIZE(12), .READ_LATENCY(1),
        .READ_DURING_WRITE("OLD_DATA"), .RESET_VALUE(32'h0)
    ) u_old (
        .clk(clk), .reset(reset), .write_en(write_en), .write_byte_en(write_byte_en),
        .write_adr(write_adr), .write_data(write_data), .read_en(read_en),
        .read_adr(read_adr), .read_reg_en(read_reg_en), .read_data(rd_old)
    );

    alt_sync_ram #(
        .DATA_WIDTH(32), .BYTE_WIDTH(8), .SIZE(12), .READ_LATENCY(1),
        .READ_DURING_WRITE("NEW_DATA"), .RESET_VALUE(32'h0)
    ) u_new (
        .clk(clk), .reset(reset), .write_en(write_en), .write_byte_en(write_byte_en),
        .write_adr(write_adr), .write_data(write_data), .read_en(read_en),
        .read_adr(read_adr), .read_reg_en(read_reg_en), .read_data(rd_new)
    );

    alt_sync_ram #(
        .DATA_WIDTH(32), .BYTE_WIDTH(8), .SIZE(12), .READ_LATENCY(2),
        .READ_DURING_WRITE("DONT_CARE"), .RESET_VALUE(c_l2_rst)
    ) u_lat2 (
        .clk(clk), .reset(reset), .write_en(write_en), .write_byte_en(write_byte_en),
        .write_adr(write_adr), .write_data(write_data), .read_en(read_en),
        .read_adr(read_adr), .read_reg_en(read_reg_en), .read_data(rd_l2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    // One clock: apply inputs, take the edge, return 1 time unit after it.
    task automatic step(input logic we, input logic [3:0] be, input logic [3:0] wa,
                        input logic [31:0] wd, input logic re, input logic [3:0] ra);
        write_en      = we;
        write_byte_en = be;
        write_adr     = wa;
        write_data    = wd;
        read_en       = re;
        read_adr      = ra;
        @(posedge clk);
        #1;
        write_en = 1'b0;
        read_en  = 1'b0;
    endtask

    task automatic wr(input logic [3:0] wa, input logic [31:0] wd);
        step(1'b1, 4'hF, wa, wd, 1'b0, 4'h0);
    endtask

    task automatic rd(input logic [3:0] ra);
        step(1'b0, 4'h0, 4'h0, 32'h0, 1'b1, ra);
    endtask

    task automatic idle();
        step(1'b0, 4'h0, 4'h0, 32'h0, 1'b0, 4'h0);
    endtask

    initial begin
        reset         = 1'b0;
        write_en      = 1'b0;
        write_byte_en = 4'h0;
        write_adr     = 4'h0;
        write_data    = 32'h0;
        read_en       = 1'b0;
        read_adr      = 4'h0;
        read_reg_en   = 1'b1;

        idle();
        idle();
        check_eq("reset_l1", rd_old, 32'h0);
        check_eq("reset_l2", rd_l2, c_l2_rst);
        wr(4'd9, 32'h0000_0099);
        reset = 1'b1;

        // basic round trip
        wr(4'd5, 32'hDEAD_BEEF);
        rd(4'd5);
        check_eq("rt_old", rd_old, 32'hDEAD_BEEF);
        check_eq("rt_new", rd_new, 32'hDEAD_BEEF);
        rd(4'd6);
        check_eq("uninit", rd_old, 32'h0);
        check_eq("rt_l2", rd_l2, 32'hDEAD_BEEF);
        idle();
        check_eq("l2_adr6", rd_l2, 32'h0);
        rd(4'd9);
        check_eq("wr_in_reset", rd_old, 32'h0000_0099);

        // asynchronous reset mid-cycle, memory survives
        wr(4'd4, 32'h1234_5678);
        rd(4'd4);
        check_eq("pre_reset", rd_old, 32'h1234_5678);
        #3 reset = 1'b0;
        #1;
        check_eq("async_rst_l1", rd_old, 32'h0);
        check_eq("async_rst_l2", rd_l2, c_l2_rst);
        @(negedge clk);
        reset = 1'b1;
        rd(4'd5);
        check_eq("mem_persist", rd_old, 32'hDEAD_BEEF);

        // same-address collision, full word
        wr(4'd3, 32'h1111_1111);
        step(1'b1, 4'hF, 4'd3, 32'h2222_2222, 1'b1, 4'd3);
        check_eq("coll_old", rd_old, 32'h1111_1111);
        check_eq("coll_new", rd_new, 32'h2222_2222);
        rd(4'd3);
        check_eq("after_coll_old", rd_old, 32'h2222_2222);
        check_eq("after_coll_new", rd_new, 32'h2222_2222);
        idle();
        check_eq("after_coll_l2", rd_l2, 32'h2222_2222);

        // byte enables, plain and colliding
        wr(4'd7, 32'hAABB_CCDD);
        step(1'b1, 4'b0101, 4'd7, 32'h1122_3344, 1'b1, 4'd7);
        check_eq("be_coll_old", rd_old, 32'hAABB_CCDD);
        check_eq("be_coll_new", rd_new, 32'hAA22_CC44);
        rd(4'd7);
        check_eq("be_mem_old", rd_old, 32'hAA22_CC44);
        check_eq("be_mem_new", rd_new, 32'hAA22_CC44);

        // read hold while read_en is low
        wr(4'd1, 32'h0000_0001);
        rd(4'd1);
        check_eq("hold_a", rd_old, 32'h0000_0001);
        wr(4'd1, 32'h0000_0009);
        check_eq("hold_b", rd_old, 32'h0000_0001);
        idle();
        check_eq("hold_c", rd_old, 32'h0000_0001);
        rd(4'd1);
        check_eq("hold_new", rd_old, 32'h0000_0009);

        // address boundaries: 11 is last word, 12 and 13 are out of range
        wr(4'd13, 32'hFFFF_FFFF);
        rd(4'd13);
        check_eq("oor_13", rd_old, 32'h0);
        wr(4'd11, 32'hCAFE_F00D);
        rd(4'd11);
        check_eq("last_word", rd_old, 32'hCAFE_F00D);
        rd(4'd12);
        check_eq("oor_12", rd_old, 32'h0);

        // latency-2 pipeline
        wr(4'd0, 32'hA0A0_A0A0);
        wr(4'd1, 32'hB1B1_B1B1);
        wr(4'd2, 32'hC2C2_C2C2);
        rd(4'd0);
        rd(4'd1);
        check_eq("l2_a", rd_l2, 32'hA0A0_A0A0);
        rd(4'd2);
        check_eq("l2_b", rd_l2, 32'hB1B1_B1B1);
        idle();
        check_eq("l2_c", rd_l2, 32'hC2C2_C2C2);

        // output-stage stall for one cycle
        rd(4'd0);
        rd(4'd1);
        check_eq("stall_a", rd_l2, 32'hA0A0_A0A0);
        read_reg_en = 1'b0;
        idle();
        check_eq("stall_hold", rd_l2, 32'hA0A0_A0A0);
        read_reg_en = 1'b1;
        rd(4'd2);
        check_eq("stall_b", rd_l2, 32'hB1B1_B1B1);
        idle();
        check_eq("stall_c", rd_l2, 32'hC2C2_C2C2);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/alt_sync_ram.md
Name: alt_sync_ram

Overview:
- Synchronous simple-dual-port block RAM: one write port, one read port, single clock.
- Vendor-neutral behavioural model of the FPGA dual-port RAM primitive that wraps under the 1R1W SRAM abstraction.
- Registered read, configurable latency, byte-granular writes and a selectable mixed-port read-during-write policy.
- Reset clears only the read pipeline, never the array.

Parameters:
- DATA_WIDTH, 32, bits per word; must be a multiple of BYTE_WIDTH.
- BYTE_WIDTH, 32, bits per write-enable lane; equal to DATA_WIDTH gives whole-word writes.
- SIZE, 1024, number of words; 1 ≤ SIZE ≤ 2**ADDR_WIDTH.
- ADDR_WIDTH, $clog2(SIZE), address bits for both ports.
- READ_LATENCY, 1, clocks from address to data; legal values 1 or 2.
- READ_DURING_WRITE, "OLD_DATA", same-address collision policy: "OLD_DATA", "NEW_DATA" or "DONT_CARE".
- RESET_VALUE, 0, value loaded into the read_data pipeline registers on reset.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low; clears the read pipeline.
- write_en  in  1  write strobe.
- write_byte_en  in  DATA_WIDTH/BYTE_WIDTH  lane enables, qualified by write_en.
- write_adr  in  ADDR_WIDTH  write address.
- write_data  in  DATA_WIDTH  write data.
- read_en  in  1  read strobe.
- read_adr  in  ADDR_WIDTH  read address.
- read_reg_en  in  1  output-stage enable; used only when READ_LATENCY=2, ignored otherwise.
- read_data  out  DATA_WIDTH  read result.

Behaviour:
- Interface decision: one clock; reset is asynchronous and active-low.
- Reset assertion: immediately sets every read pipeline register to RESET_VALUE. read_data = RESET_VALUE while reset is asserted.
- Reset does not modify the memory array; contents persist across reset.
- Writes issued during reset are still performed.
- Write: at the rising edge with write_en=1, for each lane i with write_byte_en[i]=1, mem[write_adr][i*BYTE_WIDTH +: BYTE_WIDTH] <= write_data lane i. Disabled lanes are unchanged.
- Out-of-range write (write_adr ≥ SIZE): ignored.
- Read, stage 1: at the rising edge with read_en=1, stage1 <= mem[read_adr].
- Out-of-range read (read_adr ≥ SIZE): stage1 <= 0.
- read_en=0: stage1 holds its previous value.
- READ_LATENCY=1: read_data = stage1, valid one cycle after read_en.
- READ_LATENCY=2: stage2 <= stage1 on edges where read_reg_en=1; read_data = stage2. With read_reg_en held high, data is valid two cycles after read_en.
- Collision (same edge, read_en=1, write_en=1, read_adr==write_adr, in range):
  - OLD_DATA: stage1 gets the pre-write word.
  - NEW_DATA: stage1 gets the post-write word, i.e. enabled lanes from write_data and disabled lanes from the old word. Implement as a registered bypass.
  - DONT_CARE: stage1 is unspecified but X-free; the bench must not check it. Implementations may reuse the OLD_DATA path.
- A collision never corrupts the stored word.
- Different read and write addresses in the same cycle: fully independent.
- Uninitialised words read as 0 at simulation start; all memory initialised to 0 at time zero.
- No combinational path from any input to read_data.

Test Plan:
- Basic round trip (LATENCY=1, DATA_WIDTH=32): write 0xDEADBEEF to adr 5; next cycle read adr 5 -> read_data=0xDEADBEEF one cycle after read_en. Then read adr 6 -> 0.
- Reset behaviour (RESET_VALUE=0):
  - Load read_data=0x12345678, then pull reset low mid-cycle -> read_data=0 immediately, without waiting for a clock edge.
  - Release reset and re-read adr 5 -> 0xDEADBEEF, showing memory survived reset.
- Collision, same edge: mem[3]=0x11111111; write 0x22222222 to adr 3 while reading adr 3.
  - OLD_DATA -> 0x11111111.
  - NEW_DATA -> 0x22222222.
  - A following read of adr 3 -> 0x22222222 in all modes.
- Byte enables (BYTE_WIDTH=8):
  - mem[7]=0xAABBCCDD; write 0x11223344 with write_byte_en=4'b0101 -> mem[7] reads 0xAA22CC44.
  - Same write colliding with a read of adr 7 under NEW_DATA -> 0xAA22CC44.
- Read hold: read adr 1 (=0x1), then drop read_en and write adr 1=0x9 -> read_data stays 0x1 until the next read_en.
- Latency-2 pipeline, read_reg_en=1, back-to-back reads of adr 0,1,2 (=A,B,C) -> A,B,C appear on cycles +2,+3,+4.
  - Drop read_reg_en for one cycle -> the current output holds for that cycle, then the sequence resumes.
